// File: rtl/stage_if.sv
// stage_if: instruction-fetch stage of the five-stage pipeline.
// Owns the program counter and fetches one word per PC over a req/ack
// instruction-memory handshake. It registers the fetched instruction and
// its PC+4 into the IF/ID boundary that feeds decode.
// Optional feature: define STAGE_IF_SKID_EN to compile in a one-entry skid
// register. The skid keeps a word that arrives during a decode stall, so
// that word is never fetched a second time.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] EndStageIF_Inst,
    output logic [31:0] EndStageIF_NewPC,
    output logic        EndStageIF_Valid
);

`ifdef STAGE_IF_SKID_EN
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;
`else
    typedef enum logic {
        FETCH = 1'b0
    } state_t;
`endif

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_newPc;
    logic        r_valid;

`ifdef STAGE_IF_SKID_EN
    logic [31:0] r_skidInst;
    logic [31:0] r_skidNewPc;
`endif

    logic [31:0] w_pcPlus4;
    logic [31:0] w_redirectTarget;
    logic        w_unusedRedirectLow;

    // Instructions are word aligned, so the low two bits of a redirect
    // target are forced to zero and otherwise ignored.
    assign w_pcPlus4           = r_pc + 32'd4;
    assign w_redirectTarget    = {RedirectPC[31:2], 2'b00};
    assign w_unusedRedirectLow = ^RedirectPC[1:0];

    assign IMem_Req         = (r_state == FETCH);
    assign IMem_Addr        = r_pc;
    assign EndStageIF_Inst  = r_inst;
    assign EndStageIF_NewPC = r_newPc;
    assign EndStageIF_Valid = r_valid;

    // Fetch control: reset wins over redirect, and redirect wins over any
    // ack or stall handling in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc    <= {RESET_PC[31:2], 2'b00};
            r_state <= FETCH;
            r_inst  <= '0;
            r_newPc <= '0;
            r_valid <= 1'b0;
`ifdef STAGE_IF_SKID_EN
            r_skidInst  <= '0;
            r_skidNewPc <= '0;
`endif
        end else if (Redirect) begin
            // A same-cycle ack and any skid contents belong to the
            // abandoned path, so they are dropped.
            r_pc    <= w_redirectTarget;
            r_state <= FETCH;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (!Stall) begin
                        if (IMem_Ack) begin
                            r_inst  <= IMem_Data;
                            r_newPc <= w_pcPlus4;
                            r_valid <= 1'b1;
                            r_pc    <= w_pcPlus4;
                        end else begin
                            r_valid <= 1'b0;
                        end
                    end
`ifdef STAGE_IF_SKID_EN
                    else if (IMem_Ack) begin
                        r_skidInst  <= IMem_Data;
                        r_skidNewPc <= w_pcPlus4;
                        r_pc        <= w_pcPlus4;
                        r_state     <= HOLD;
                    end
`endif
                end
`ifdef STAGE_IF_SKID_EN
                HOLD: begin
                    if (!Stall) begin
                        r_inst  <= r_skidInst;
                        r_newPc <= r_skidNewPc;
                        r_valid <= 1'b1;
                        r_state <= FETCH;
                    end
                end
`endif
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: self-checking bench for stage_if.
// A memory model answers the presented address after a programmable wait.
// It returns 32'h1000_0000 + address. A transaction-level model predicts
// every output each cycle, and directed literal checks pin key cycles.
module tb_stage_if;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack = 1'b0;
    logic [31:0] IMem_Data = '0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic [31:0] EndStageIF_Inst;
    logic [31:0] EndStageIF_NewPC;
    logic        EndStageIF_Valid;

    int checkCount = 0;
    int failCount  = 0;

    int          memDelay    = 0;
    int          memWait     = 0;
    logic        memPrevReq  = 1'b0;
    logic [31:0] memLastAddr = '0;

    bit          modelKnown = 1'b0;
    logic [31:0] mPc;
    logic [31:0] mInst;
    logic [31:0] mNewPc;
    logic        mValid;
    logic [63:0] skidQ[$];

    stage_if #(.RESET_PC(RESET_PC)) dut (
        .clock            (clock),
        .reset            (reset),
        .IMem_Req         (IMem_Req),
        .IMem_Addr        (IMem_Addr),
        .IMem_Ack         (IMem_Ack),
        .IMem_Data        (IMem_Data),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectPC       (RedirectPC),
        .EndStageIF_Inst  (EndStageIF_Inst),
        .EndStageIF_NewPC (EndStageIF_NewPC),
        .EndStageIF_Valid (EndStageIF_Valid)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One full cycle. Drive the control inputs and let the memory answer
    // the address now presented. Then advance to just after the next edge.
    task automatic applyStimulus(input logic rs, input logic st, input logic rd,
                                 input logic [31:0] rpc);
        reset      = rs;
        Stall      = st;
        Redirect   = rd;
        RedirectPC = rpc;
        if (IMem_Req === 1'b1 && memPrevReq && IMem_Addr === memLastAddr)
            memWait++;
        else
            memWait = 0;
        memPrevReq  = (IMem_Req === 1'b1);
        memLastAddr = IMem_Addr;
        IMem_Ack    = (IMem_Req === 1'b1) && (memWait >= memDelay);
        IMem_Data   = IMem_Ack ? (32'h1000_0000 + IMem_Addr) : 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
    endtask

    task automatic expectState(input string tag, input logic [31:0] inst,
                               input logic [31:0] newPc, input logic valid,
                               input logic [31:0] addr, input logic req);
        checkOutput({tag, ".inst"},  EndStageIF_Inst,           inst);
        checkOutput({tag, ".newpc"}, EndStageIF_NewPC,          newPc);
        checkOutput({tag, ".valid"}, {31'd0, EndStageIF_Valid}, {31'd0, valid});
        checkOutput({tag, ".addr"},  IMem_Addr,                 addr);
        checkOutput({tag, ".req"},   {31'd0, IMem_Req},         {31'd0, req});
    endtask

    // Transaction model: one word is accepted per cycle unless the cycle
    // stalls. Skid occupancy is a queue, and reset or redirect clears it.
    always @(posedge clock) begin
        if (reset) begin
            mPc    = {RESET_PC[31:2], 2'b00};
            mInst  = '0;
            mNewPc = '0;
            mValid = 1'b0;
            skidQ.delete();
            modelKnown = 1'b1;
        end else if (modelKnown) begin
            if (Redirect) begin
                mPc    = RedirectPC & 32'hFFFF_FFFC;
                mValid = 1'b0;
                skidQ.delete();
            end else if (skidQ.size() != 0) begin
                if (!Stall) begin
                    {mInst, mNewPc} = skidQ.pop_front();
                    mValid = 1'b1;
                end
            end else if (!Stall) begin
                if (IMem_Ack) begin
                    mInst  = IMem_Data;
                    mNewPc = mPc + 32'd4;
                    mValid = 1'b1;
                    mPc    = mPc + 32'd4;
                end else begin
                    mValid = 1'b0;
                end
            end else if (IMem_Ack) begin
`ifdef STAGE_IF_SKID_EN
                skidQ.push_back({IMem_Data, mPc + 32'd4});
                mPc = mPc + 32'd4;
`endif
            end
        end
    end

    // Every-cycle comparison against the model, half a cycle from the edge.
    always @(negedge clock) begin
        if (modelKnown) begin
            checkOutput("model.req",   {31'd0, IMem_Req}, {31'd0, (skidQ.size() == 0)});
            checkOutput("model.addr",  IMem_Addr,         mPc);
            checkOutput("model.inst",  EndStageIF_Inst,   mInst);
            checkOutput("model.newpc", EndStageIF_NewPC,  mNewPc);
            checkOutput("model.valid", {31'd0, EndStageIF_Valid}, {31'd0, mValid});
        end
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        logic [23:0] stallPattern;
        stallPattern = 24'b0110_0011_1000_1101_0010_0111;

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        expectState("reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Zero-wait memory: one instruction per cycle.
        memDelay = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        expectState("zw0", 32'h1000_0000, 32'h4, 1'b1, 32'h4, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        expectState("zw1", 32'h1000_0004, 32'h8, 1'b1, 32'h8, 1'b1);

        // Two-cycle ack delay: the address is held for three cycles.
        memDelay = 2;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        expectState("wait0", 32'h1000_0004, 32'h8, 1'b0, 32'h8, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        expectState("wait1", 32'h1000_0004, 32'h8, 1'b0, 32'h8, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        expectState("wait2", 32'h1000_0008, 32'hC, 1'b1, 32'hC, 1'b1);

        // Stall for three cycles while the word at 0xC is acked.
        memDelay = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
`ifdef STAGE_IF_SKID_EN
        expectState("stall", 32'h1000_0008, 32'hC, 1'b1, 32'h10, 1'b0);
`else
        expectState("stall", 32'h1000_0008, 32'hC, 1'b1, 32'hC, 1'b1);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        expectState("unstall", 32'h1000_000C, 32'h10, 1'b1, 32'h10, 1'b1);

        // Redirect together with a stall and an ack: the acked word is lost.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0203);
        expectState("redir", 32'h1000_000C, 32'h10, 1'b0, 32'h200, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        expectState("redir1", 32'h1000_0200, 32'h204, 1'b1, 32'h204, 1'b1);

        // Fetch at the top of the address space wraps to zero.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        expectState("wrap0", 32'h1000_0200, 32'h204, 1'b0, 32'hFFFF_FFFC, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        expectState("wrap1", 32'h0FFF_FFFC, 32'h0, 1'b1, 32'h0, 1'b1);

        // Reset while stalled with a valid word (HOLD in the skid build).
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        expectState("rstHold", 32'h0, 32'h0, 1'b0, RESET_PC, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        expectState("rstHold1", 32'h1000_0000, 32'h4, 1'b1, 32'h4, 1'b1);

        // Mixed stalls with a one-cycle memory and one mid-stream redirect.
        memDelay = 1;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0, stallPattern[i], (i == 15), 32'h0000_0100);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage of the five-stage pipeline CPU, directly upstream of the decode stage. It owns the program counter and fetches one 32-bit word per PC from an instruction memory over a req/ack handshake. It registers the instruction and its PC+4 into the IF/ID boundary outputs that feed decode. It honours a stall from the hazard logic and a redirect (branch/jump) from later stages.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset (bits [1:0] must be 0).
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `IMem_Req` out 1: fetch request, combinational, = (state == FETCH).
- `IMem_Addr` out 32: fetch address, = PC.
- `IMem_Ack` in 1: memory returns `IMem_Data` for the current `IMem_Addr` this cycle.
- `IMem_Data` in 32: instruction word, valid only with `IMem_Ack`.
- `Stall` in 1: decode cannot accept; IF/ID outputs must hold.
- `Redirect` in 1: load PC from `RedirectPC` and flush.
- `RedirectPC` in 32: redirect target.
- `EndStageIF_Inst` out 32: registered instruction to decode.
- `EndStageIF_NewPC` out 32: registered PC+4 of that instruction.
- `EndStageIF_Valid` out 1: registered; 0 marks a bubble.

## Operation
- States: FETCH (request outstanding), HOLD (word captured, waiting for `Stall` to drop; skid build only).
- Memory contract: `IMem_Addr` is held stable while `IMem_Req` = 1 until `IMem_Ack`, except on redirect. A changed address abandons the old request, and the memory answers only the currently presented address. `IMem_Ack` arrives 0..N cycles after the request is presented.
- Priority per cycle: `reset` > `Redirect` > ack/stall handling.
- Redirect, in any state, including during `Stall`:
  - PC <= {RedirectPC[31:2], 2'b00}; state <= FETCH.
  - `EndStageIF_Valid` <= 0; `Inst`/`NewPC` hold.
  - Skid contents discarded; a same-cycle `IMem_Ack` is discarded.
- FETCH, `IMem_Ack` = 1, `Stall` = 0:
  - Inst <= IMem_Data; NewPC <= PC+4; Valid <= 1; PC <= PC+4.
- FETCH, `IMem_Ack` = 0, `Stall` = 0: Valid <= 0 (bubble); Inst/NewPC hold.
- `Stall` = 1 with no redirect: Inst, NewPC and Valid all hold.
- FETCH, `IMem_Ack` = 1, `Stall` = 1: see Configuration.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. PC[1:0] is always 00.

## Timing
- Reset values after the reset edge:
  - PC = RESET_PC, state = FETCH.
  - `EndStageIF_Inst` = 0, `EndStageIF_NewPC` = 0, `EndStageIF_Valid` = 0.
  - Skid empty.
- Consequence: `IMem_Req` = 1 and `IMem_Addr` = RESET_PC in the first cycle after reset.
- Latency: an ack in cycle n (no stall) puts the instruction on the outputs in cycle n+1. The new PC is presented on `IMem_Addr` in cycle n+1.
- Throughput: one instruction per cycle with a zero-wait memory.
- Redirect in cycle n: `IMem_Addr` = target in cycle n+1; Valid = 0 in cycle n+1. The first target instruction appears no earlier than n+2.
- Reset asserted mid-fetch or in HOLD: everything returns to reset values next cycle. A late ack for the abandoned address is not expected.

## Configuration
- `STAGE_IF_SKID_EN` defined: a 1-entry skid register (32-bit word + its PC+4) is compiled in.
  - FETCH + ack + Stall: capture the word into skid; PC <= PC+4; state <= HOLD.
  - In HOLD, `IMem_Req` = 0.
  - HOLD + !Stall: outputs <= skid, Valid <= 1; state <= FETCH.
  - No fetched word is ever re-requested.
- Undefined: no skid, no HOLD state.
  - FETCH + ack + Stall: data dropped; PC unchanged; request stays asserted.
  - The same address is re-fetched after the stall, costing at least one extra memory access.

## Test plan
- Reset, RESET_PC = 0, zero-wait memory returning 32'h1000_0000+addr -> `IMem_Addr` 0, 4, 8 on consecutive cycles. Outputs (Inst, NewPC, Valid) = (0x1000_0000, 4, 1), then (0x1000_0004, 8, 1).
- Memory with 2-cycle ack delay -> `IMem_Addr` stable for 3 cycles. Valid = 0 for 2 cycles, then 1 for one cycle per word.
- `Stall` held 3 cycles while an ack arrives (skid build) -> outputs frozen during the stall. `IMem_Req` = 0 in HOLD. The skid word appears the cycle after `Stall` falls, with no repeat fetch of that address. Non-skid build: the same address is re-requested after the stall.
- `Redirect` = 1, `RedirectPC` = 32'h0000_0203, together with `Stall` = 1 and `IMem_Ack` = 1 -> next cycle `IMem_Addr` = 0x200 and Valid = 0. The acked word never appears.
- PC = 32'hFFFF_FFFC fetched -> NewPC = 0 and next `IMem_Addr` = 0.
- `reset` asserted while in HOLD with Valid = 1 -> next cycle all outputs 0, PC = RESET_PC, `IMem_Req` = 1.
